// File: rtl/tictac_pkg.sv
// Shared definitions for the tic-tac-toe board controller: FSM states,
// winner codes, grid boundaries and the eight winning line masks.
package tictac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        COMMIT,
        CHECK,
        OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [11:0] COL0_END   = 12'd341;
    localparam logic [11:0] COL1_START = 12'd343;
    localparam logic [11:0] COL1_END   = 12'd683;
    localparam logic [11:0] COL2_START = 12'd685;
    localparam logic [11:0] H_MAX      = 12'd1023;
    localparam logic [11:0] ROW0_END   = 12'd257;
    localparam logic [11:0] ROW1_START = 12'd259;
    localparam logic [11:0] ROW1_END   = 12'd507;
    localparam logic [11:0] ROW2_START = 12'd509;
    localparam logic [11:0] V_MAX      = 12'd767;

    localparam logic [8:0] FULL_BOARD = 9'h1FF;

    // Bit k is square k+1, row-major: three rows, three columns, two diagonals.
    localparam logic [7:0][8:0] LINE_MASKS = {
        9'b000_000_111,
        9'b000_111_000,
        9'b111_000_000,
        9'b001_001_001,
        9'b010_010_010,
        9'b100_100_100,
        9'b100_010_001,
        9'b001_010_100
    };

    function automatic logic has_line(input logic [8:0] board);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((board & LINE_MASKS[i]) == LINE_MASKS[i]) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/square_decode.sv
// Combinational map from a screen coordinate to a board square index.
// Grid-line pixels and anything beyond the board report valid=0.
module square_decode
    import tictac_pkg::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic        valid,
    output logic [3:0]  idx
);

    logic       col_ok;
    logic       row_ok;
    logic [1:0] col;
    logic [1:0] row;

    always_comb begin
        col_ok = 1'b1;
        col    = 2'd0;
        if (x <= COL0_END) begin
            col = 2'd0;
        end else if (x >= COL1_START && x <= COL1_END) begin
            col = 2'd1;
        end else if (x >= COL2_START && x <= H_MAX) begin
            col = 2'd2;
        end else begin
            col_ok = 1'b0;
        end

        row_ok = 1'b1;
        row    = 2'd0;
        if (y <= ROW0_END) begin
            row = 2'd0;
        end else if (y >= ROW1_START && y <= ROW1_END) begin
            row = 2'd1;
        end else if (y >= ROW2_START && y <= V_MAX) begin
            row = 2'd2;
        end else begin
            row_ok = 1'b0;
        end

        valid = col_ok & row_ok;
        // 3*row + col without a multiplier
        idx   = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
    end

endmodule

// File: rtl/square_select_ctl.sv
// Turns left-clicks into square claims for alternating players and flags
// the win/draw outcome; all outputs are registered on pclk.
module square_select_ctl
    import tictac_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        new_game,
    output logic [8:0]  square_x,
    output logic [8:0]  square_o,
    output logic        turn,
    output logic        move_valid,
    output logic        move_reject,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t      state;
    state_t      next_state;
    logic        left_d;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic [8:0]  sel_q;

    logic        click;
    logic        dec_valid;
    logic [3:0]  dec_idx;
    logic [8:0]  dec_mask;
    logic        occupied;
    logic        reject;
    logic [8:0]  moved_board;
    logic        win;
    logic        full;

    logic [11:0] x_q_nxt;
    logic [11:0] y_q_nxt;
    logic [8:0]  sel_q_nxt;
    logic [8:0]  square_x_nxt;
    logic [8:0]  square_o_nxt;
    logic        turn_nxt;
    logic        move_valid_nxt;
    logic        move_reject_nxt;
    logic        game_over_nxt;
    logic [1:0]  winner_nxt;

    square_decode u_decode (
        .x     (x_q),
        .y     (y_q),
        .valid (dec_valid),
        .idx   (dec_idx)
    );

    // turn has already flipped by CHECK, so turn=1 means X just moved
    always_comb begin
        click       = mouse_left & ~left_d;
        dec_mask    = 9'b1 << dec_idx;
        occupied    = |((square_x | square_o) & dec_mask);
        reject      = ~dec_valid | occupied;
        moved_board = turn ? square_x : square_o;
        win         = has_line(moved_board);
        full        = ((square_x | square_o) == FULL_BOARD);
    end

    always_ff @(posedge pclk) begin
        if (rst || new_game) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (click) next_state = DECODE;
            DECODE:  next_state = reject ? IDLE : COMMIT;
            COMMIT:  next_state = CHECK;
            CHECK:   next_state = (win || full) ? OVER : IDLE;
            OVER:    next_state = OVER;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        x_q_nxt         = x_q;
        y_q_nxt         = y_q;
        sel_q_nxt       = sel_q;
        square_x_nxt    = square_x;
        square_o_nxt    = square_o;
        turn_nxt        = turn;
        move_valid_nxt  = 1'b0;
        move_reject_nxt = 1'b0;
        game_over_nxt   = game_over;
        winner_nxt      = winner;
        case (state)
            IDLE: begin
                if (click) begin
                    x_q_nxt = xpos;
                    y_q_nxt = ypos;
                end
            end
            DECODE: begin
                if (reject) begin
                    move_reject_nxt = 1'b1;
                end else begin
                    sel_q_nxt = dec_mask;
                end
            end
            COMMIT: begin
                if (!turn) begin
                    square_x_nxt = square_x | sel_q;
                end else begin
                    square_o_nxt = square_o | sel_q;
                end
                move_valid_nxt = 1'b1;
                turn_nxt       = ~turn;
            end
            CHECK: begin
                if (win) begin
                    winner_nxt    = turn ? WIN_X : WIN_O;
                    game_over_nxt = 1'b1;
                end else if (full) begin
                    winner_nxt    = WIN_DRAW;
                    game_over_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // new_game clears everything except the button history, so a held button
    // across a new game still does not count as a fresh click
    always_ff @(posedge pclk) begin
        if (rst) begin
            left_d      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sel_q       <= '0;
            square_x    <= '0;
            square_o    <= '0;
            turn        <= 1'b0;
            move_valid  <= 1'b0;
            move_reject <= 1'b0;
            game_over   <= 1'b0;
            winner      <= WIN_NONE;
        end else begin
            left_d <= mouse_left;
            if (new_game) begin
                x_q         <= '0;
                y_q         <= '0;
                sel_q       <= '0;
                square_x    <= '0;
                square_o    <= '0;
                turn        <= 1'b0;
                move_valid  <= 1'b0;
                move_reject <= 1'b0;
                game_over   <= 1'b0;
                winner      <= WIN_NONE;
            end else begin
                x_q         <= x_q_nxt;
                y_q         <= y_q_nxt;
                sel_q       <= sel_q_nxt;
                square_x    <= square_x_nxt;
                square_o    <= square_o_nxt;
                turn        <= turn_nxt;
                move_valid  <= move_valid_nxt;
                move_reject <= move_reject_nxt;
                game_over   <= game_over_nxt;
                winner      <= winner_nxt;
            end
        end
    end

endmodule

// File: tb/tb_square_select_ctl.sv
// Scoreboard bench for square_select_ctl: each click pushes its expected
// pulse and board snapshot; a negedge monitor pops and compares.
module tb_square_select_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic        mouse_left = 1'b0;
    logic        new_game = 1'b0;
    logic [8:0]  square_x;
    logic [8:0]  square_o;
    logic        turn;
    logic        move_valid;
    logic        move_reject;
    logic        game_over;
    logic [1:0]  winner;

    typedef struct {
        logic       is_valid;
        logic [8:0] sx;
        logic [8:0] so;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int         draw_sq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    logic [8:0] draw_x  [9] = '{9'h001, 9'h001, 9'h005, 9'h005, 9'h00D, 9'h00D, 9'h08D, 9'h08D, 9'h18D};
    logic [8:0] draw_o  [9] = '{9'h000, 9'h002, 9'h002, 9'h012, 9'h012, 9'h032, 9'h032, 9'h072, 9'h072};

    square_select_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .xpos        (xpos),
        .ypos        (ypos),
        .mouse_left  (mouse_left),
        .new_game    (new_game),
        .square_x    (square_x),
        .square_o    (square_o),
        .turn        (turn),
        .move_valid  (move_valid),
        .move_reject (move_reject),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 pclk = ~pclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge pclk) begin
        if (!rst && (move_valid || move_reject)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b reject=%0b, expected none",
                         move_valid, move_reject);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("pulse_valid",  {31'b0, move_valid},  {31'b0, e.is_valid});
                check_output("pulse_reject", {31'b0, move_reject}, {31'b0, ~e.is_valid});
                check_output("board_x",      {23'b0, square_x},    {23'b0, e.sx});
                check_output("board_o",      {23'b0, square_o},    {23'b0, e.so});
                check_output("turn",         {31'b0, turn},        {31'b0, e.t});
            end
        end
    end

    task automatic wait_drain(input string name);
        repeat (6) @(negedge pclk);
        check_output({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic press(input logic [11:0] x, input logic [11:0] y);
        @(negedge pclk);
        xpos       = x;
        ypos       = y;
        mouse_left = 1'b1;
        @(negedge pclk);
        mouse_left = 1'b0;
    endtask

    task automatic apply_stimulus(input string name, input logic [11:0] x, input logic [11:0] y,
                                  input logic v, input logic [8:0] sx, input logic [8:0] so,
                                  input logic t);
        exp_t e;
        e.is_valid = v;
        e.sx       = sx;
        e.so       = so;
        e.t        = t;
        exp_q.push_back(e);
        press(x, y);
        wait_drain(name);
    endtask

    task automatic check_idle_outputs(input string name);
        check_output({name, "_sq_x"},   {23'b0, square_x}, 32'h0);
        check_output({name, "_sq_o"},   {23'b0, square_o}, 32'h0);
        check_output({name, "_turn"},   {31'b0, turn}, 32'h0);
        check_output({name, "_mv"},     {31'b0, move_valid}, 32'h0);
        check_output({name, "_mr"},     {31'b0, move_reject}, 32'h0);
        check_output({name, "_over"},   {31'b0, game_over}, 32'h0);
        check_output({name, "_winner"}, {30'b0, winner}, 32'h0);
    endtask

    task automatic pulse_new_game();
        @(negedge pclk);
        new_game = 1'b1;
        @(negedge pclk);
        new_game = 1'b0;
        @(negedge pclk);
    endtask

    function automatic logic [11:0] sq_xc(input int s);
        case ((s - 1) % 3)
            0:       return 12'd100;
            1:       return 12'd500;
            default: return 12'd900;
        endcase
    endfunction

    function automatic logic [11:0] sq_yc(input int s);
        case ((s - 1) / 3)
            0:       return 12'd100;
            1:       return 12'd400;
            default: return 12'd700;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        check_idle_outputs("reset");

        // square 6 for X, then the same square rejected for O
        apply_stimulus("x_sq6", 12'd800, 12'd300, 1'b1, 9'b000100000, 9'h000, 1'b1);
        apply_stimulus("o_sq6_taken", 12'd800, 12'd300, 1'b0, 9'b000100000, 9'h000, 1'b1);
        apply_stimulus("vline", 12'd342, 12'd100, 1'b0, 9'b000100000, 9'h000, 1'b1);
        apply_stimulus("offgrid", 12'd1100, 12'd100, 1'b0, 9'b000100000, 9'h000, 1'b1);
        apply_stimulus("hline", 12'd100, 12'd258, 1'b0, 9'b000100000, 9'h000, 1'b1);
        apply_stimulus("below", 12'd100, 12'd768, 1'b0, 9'b000100000, 9'h000, 1'b1);
        check_output("after_rejects_turn", {31'b0, turn}, 32'h1);

        pulse_new_game();
        check_idle_outputs("new_game1");

        // X wins on the top row, using coordinates right at the cell edges
        apply_stimulus("win_x1", 12'd0,    12'd0,   1'b1, 9'h001, 9'h000, 1'b1);
        apply_stimulus("win_o4", 12'd341,  12'd259, 1'b1, 9'h001, 9'h008, 1'b0);
        apply_stimulus("win_x2", 12'd343,  12'd257, 1'b1, 9'h003, 9'h008, 1'b1);
        check_output("midgame_over", {31'b0, game_over}, 32'h0);
        apply_stimulus("win_o5", 12'd683,  12'd507, 1'b1, 9'h003, 9'h018, 1'b0);
        apply_stimulus("win_x3", 12'd1023, 12'd0,   1'b1, 9'h007, 9'h018, 1'b1);
        check_output("win_winner", {30'b0, winner}, 32'h1);
        check_output("win_over",   {31'b0, game_over}, 32'h1);
        press(12'd500, 12'd600);
        wait_drain("over_ignored");
        check_output("over_sq_x",   {23'b0, square_x}, 32'h007);
        check_output("over_sq_o",   {23'b0, square_o}, 32'h018);
        check_output("over_winner", {30'b0, winner}, 32'h1);

        pulse_new_game();
        check_idle_outputs("new_game2");

        for (int i = 0; i < 9; i++) begin
            apply_stimulus("draw_move", sq_xc(draw_sq[i]), sq_yc(draw_sq[i]), 1'b1,
                           draw_x[i], draw_o[i], (i % 2 == 0));
            if (i == 7) check_output("draw_not_over_yet", {31'b0, game_over}, 32'h0);
        end
        check_output("draw_winner", {30'b0, winner}, 32'h3);
        check_output("draw_over",   {31'b0, game_over}, 32'h1);

        pulse_new_game();
        check_idle_outputs("new_game3");

        // A button held for 100 cycles yields exactly one move
        begin
            exp_t e;
            e.is_valid = 1'b1;
            e.sx       = 9'h001;
            e.so       = 9'h000;
            e.t        = 1'b1;
            exp_q.push_back(e);
        end
        @(negedge pclk);
        xpos       = 12'd100;
        ypos       = 12'd100;
        mouse_left = 1'b1;
        repeat (100) @(negedge pclk);
        mouse_left = 1'b0;
        wait_drain("held_button");

        // rst lands on the COMMIT edge: the move must never appear
        press(12'd500, 12'd100);
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        repeat (5) @(negedge pclk);
        check_idle_outputs("rst_in_commit");

        apply_stimulus("after_rst", 12'd100, 12'd100, 1'b1, 9'h001, 9'h000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
